// File: rtl/mii_frame_gen.sv
// Multi-lane xMII frame generator: idle / start / payload / terminate words
// with a valid/ready handshake, error-code injection and saturating statistics.
module mii_frame_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter logic [7:0]  IDLE_CODE  = 8'h07,
  parameter logic [7:0]  START_CODE = 8'hFB,
  parameter logic [7:0]  EOF_CODE   = 8'hFD,
  parameter logic [7:0]  ERROR_CODE = 8'hFE,
  parameter logic [31:0] LFSR_SEED  = 32'hACE11234
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [1:0]              i_mode,
  input  logic [7:0]              i_pattern,
  input  logic [LEN_WIDTH-1:0]    i_idle_len,
  input  logic [LEN_WIDTH-1:0]    i_data_len,
  input  logic                    i_err_inject,
  input  logic                    i_clr_cnt,
  input  logic                    i_ready,
  output logic                    o_tx_valid,
  output logic [DATA_WIDTH-1:0]   o_tx_data,
  output logic [DATA_WIDTH/8-1:0] o_tx_ctrl,
  output logic                    o_busy,
  output logic [CNT_WIDTH-1:0]    o_frame_cnt,
  output logic [CNT_WIDTH-1:0]    o_data_char_cnt,
  output logic [CNT_WIDTH-1:0]    o_ctrl_char_cnt,
  output logic [CNT_WIDTH-1:0]    o_err_cnt
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned PW = $clog2(NB + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_TERM  = 2'd3;

  localparam logic [1:0] MODE_FIXED = 2'b00;
  localparam logic [1:0] MODE_INC   = 2'b01;
  localparam logic [1:0] MODE_LFSR  = 2'b10;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  logic                  xfer;
  logic [1:0]            state,    state_d;
  logic [LEN_WIDTH-1:0]  idle_cnt, idle_cnt_d;
  logic [LEN_WIDTH-1:0]  data_cnt, data_cnt_d;
  logic [LEN_WIDTH-1:0]  lat_len,  lat_len_d;
  logic [1:0]            lat_mode, lat_mode_d;
  logic [7:0]            lat_pat,  lat_pat_d;
  logic [7:0]            base,     base_d;
  logic [31:0]           lfsr,     lfsr_d;
  logic                  err_pend, err_pend_d;
  logic                  cur_err,  cur_err_d;
  logic [DATA_WIDTH-1:0] word_d;
  logic [NB-1:0]         ctrl_d;
  logic [PW-1:0]         n_ctrl;
  logic [PW-1:0]         n_data;

  assign xfer = o_tx_valid & i_ready;

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [CNT_WIDTH-1:0] b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // FSM state and frame-context registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      idle_cnt <= LEN_WIDTH'(1);
      data_cnt <= '0;
      lat_len  <= '0;
      lat_mode <= MODE_FIXED;
      lat_pat  <= '0;
      base     <= '0;
      lfsr     <= LFSR_SEED;
      err_pend <= 1'b0;
    end else begin
      state    <= state_d;
      idle_cnt <= idle_cnt_d;
      data_cnt <= data_cnt_d;
      lat_len  <= lat_len_d;
      lat_mode <= lat_mode_d;
      lat_pat  <= lat_pat_d;
      base     <= base_d;
      lfsr     <= lfsr_d;
      err_pend <= err_pend_d;
    end
  end

  // Next-state logic; everything advances only on a transfer
  always_comb begin
    state_d    = state;
    idle_cnt_d = idle_cnt;
    data_cnt_d = data_cnt;
    lat_len_d  = lat_len;
    lat_mode_d = lat_mode;
    lat_pat_d  = lat_pat;
    base_d     = base;
    lfsr_d     = lfsr;
    // a pulse while a request is already pending is absorbed, not queued
    err_pend_d = (xfer && cur_err) ? 1'b0 : (err_pend | i_err_inject);
    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (idle_cnt > LEN_WIDTH'(1)) begin
            idle_cnt_d = idle_cnt - LEN_WIDTH'(1);
          end else if (i_enable) begin
            state_d    = S_START;
            lat_len_d  = i_data_len;
            lat_mode_d = (i_mode == 2'b11) ? MODE_FIXED : i_mode;
            lat_pat_d  = i_pattern;
            base_d     = i_pattern;
          end
        end
      end
      S_START: begin
        if (xfer) begin
          if (lat_len != '0) begin
            state_d    = S_DATA;
            data_cnt_d = lat_len;
          end else begin
            state_d = S_TERM;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          if (lat_mode == MODE_LFSR) begin
            lfsr_d = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
          end
          base_d = base + 8'(NB);
          if (data_cnt > LEN_WIDTH'(1)) begin
            data_cnt_d = data_cnt - LEN_WIDTH'(1);
          end else begin
            state_d = S_TERM;
          end
        end
      end
      S_TERM: begin
        if (xfer) begin
          state_d    = S_IDLE;
          idle_cnt_d = (i_idle_len == '0) ? LEN_WIDTH'(1) : i_idle_len;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word that will be presented after the current transfer
  always_comb begin
    word_d    = '0;
    ctrl_d    = '0;
    cur_err_d = 1'b0;
    case (state_d)
      S_START: begin
        for (int k = 0; k < NB; k++) begin
          word_d[8*k +: 8] = 8'h55;
        end
        word_d[7:0]                    = START_CODE;
        word_d[DATA_WIDTH-1 -: 8]      = 8'hD5;
        ctrl_d[0]                      = 1'b1;
      end
      S_DATA: begin
        for (int k = 0; k < NB; k++) begin
          case (lat_mode_d)
            MODE_INC:  word_d[8*k +: 8] = base_d + 8'(k);
            MODE_LFSR: word_d[8*k +: 8] = lfsr_d[8*(k%4) +: 8];
            default:   word_d[8*k +: 8] = lat_pat_d;
          endcase
        end
        if (err_pend_d) begin
          word_d[7:0] = ERROR_CODE;
          ctrl_d[0]   = 1'b1;
          cur_err_d   = 1'b1;
        end
      end
      S_TERM: begin
        for (int k = 0; k < NB; k++) begin
          word_d[8*k +: 8] = IDLE_CODE;
        end
        word_d[7:0] = EOF_CODE;
        ctrl_d      = '1;
      end
      default: begin
        for (int k = 0; k < NB; k++) begin
          word_d[8*k +: 8] = IDLE_CODE;
        end
        ctrl_d = '1;
      end
    endcase
  end

  // Output word register; held while the sink stalls
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= {NB{IDLE_CODE}};
      o_tx_ctrl  <= '1;
      o_busy     <= 1'b0;
      cur_err    <= 1'b0;
    end else begin
      o_tx_valid <= 1'b1;
      o_busy     <= (state_d != S_IDLE);
      if (xfer) begin
        o_tx_data <= word_d;
        o_tx_ctrl <= ctrl_d;
        cur_err   <= cur_err_d;
      end
    end
  end

  // Lane classification of the word currently presented
  always_comb begin
    n_ctrl = '0;
    for (int k = 0; k < NB; k++) begin
      n_ctrl = n_ctrl + PW'(o_tx_ctrl[k]);
    end
    n_data = PW'(NB) - n_ctrl;
  end

  // Saturating statistics; clear wins over a same-cycle transfer
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt     <= '0;
      o_data_char_cnt <= '0;
      o_ctrl_char_cnt <= '0;
      o_err_cnt       <= '0;
    end else if (i_clr_cnt) begin
      o_frame_cnt     <= '0;
      o_data_char_cnt <= '0;
      o_ctrl_char_cnt <= '0;
      o_err_cnt       <= '0;
    end else if (xfer) begin
      o_data_char_cnt <= sat_add(o_data_char_cnt, CNT_WIDTH'(n_data));
      o_ctrl_char_cnt <= sat_add(o_ctrl_char_cnt, CNT_WIDTH'(n_ctrl));
      if (state == S_TERM) begin
        o_frame_cnt <= sat_add(o_frame_cnt, CNT_WIDTH'(1));
      end
      if (cur_err) begin
        o_err_cnt <= sat_add(o_err_cnt, CNT_WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_mii_frame_gen.sv
// Directed bench for mii_frame_gen (64-bit bus, 8-bit counters).
module tb_mii_frame_gen;

  localparam int unsigned DW = 64;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 8;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] AA_W    = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] ERR_W   = 64'hAAAAAAAAAAAAAAFE;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_enable;
  logic [1:0]    i_mode;
  logic [7:0]    i_pattern;
  logic [LW-1:0] i_idle_len;
  logic [LW-1:0] i_data_len;
  logic          i_err_inject;
  logic          i_clr_cnt;
  logic          i_ready;
  logic          o_tx_valid;
  logic [DW-1:0] o_tx_data;
  logic [7:0]    o_tx_ctrl;
  logic          o_busy;
  logic [CW-1:0] o_frame_cnt;
  logic [CW-1:0] o_data_char_cnt;
  logic [CW-1:0] o_ctrl_char_cnt;
  logic [CW-1:0] o_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit stall_en = 1'b0;

  mii_frame_gen #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_mode         (i_mode),
    .i_pattern      (i_pattern),
    .i_idle_len     (i_idle_len),
    .i_data_len     (i_data_len),
    .i_err_inject   (i_err_inject),
    .i_clr_cnt      (i_clr_cnt),
    .i_ready        (i_ready),
    .o_tx_valid     (o_tx_valid),
    .o_tx_data      (o_tx_data),
    .o_tx_ctrl      (o_tx_ctrl),
    .o_busy         (o_busy),
    .o_frame_cnt    (o_frame_cnt),
    .o_data_char_cnt(o_data_char_cnt),
    .o_ctrl_char_cnt(o_ctrl_char_cnt),
    .o_err_cnt      (o_err_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check the presented word (optionally after random stall cycles), then let it transfer
  task automatic send(input string tag, input logic [63:0] d, input logic [7:0] c);
    int  n;
    logic exp_busy;
    n = 0;
    if (stall_en && ($urandom_range(0, 9) < 4)) n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      i_ready = 1'b0;
      @(negedge clk);
      check({tag, "_hold_d"}, o_tx_data, d);
      check({tag, "_hold_c"}, 64'(o_tx_ctrl), 64'(c));
    end
    i_ready  = 1'b1;
    exp_busy = !((d == IDLE_W) && (c == 8'hFF));
    check({tag, "_valid"}, 64'(o_tx_valid), 64'd1);
    check({tag, "_data"}, o_tx_data, d);
    check({tag, "_ctrl"}, 64'(o_tx_ctrl), 64'(c));
    check({tag, "_busy"}, 64'(o_busy), 64'(exp_busy));
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input int d, input int c, input int f, input int e);
    check({tag, "_data_chars"}, 64'(o_data_char_cnt), 64'(d));
    check({tag, "_ctrl_chars"}, 64'(o_ctrl_char_cnt), 64'(c));
    check({tag, "_frames"}, 64'(o_frame_cnt), 64'(f));
    check({tag, "_errs"}, 64'(o_err_cnt), 64'(e));
  endtask

  task automatic fixed_frame(input string tag, input int idles, input int len);
    for (int i = 0; i < idles; i++) send({tag, "_idle"}, IDLE_W, 8'hFF);
    send({tag, "_start"}, START_W, 8'h01);
    for (int i = 0; i < len; i++) send({tag, "_aa"}, AA_W, 8'h00);
    send({tag, "_term"}, TERM_W, 8'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n      = 1'b0;
    i_enable     = 1'b0;
    i_mode       = 2'b00;
    i_pattern    = 8'hAA;
    i_idle_len   = 16'd2;
    i_data_len   = 16'd3;
    i_err_inject = 1'b0;
    i_clr_cnt    = 1'b0;
    i_ready      = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(o_tx_valid), 64'd0);
    check("rst_data", o_tx_data, IDLE_W);
    check("rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
    check("rst_busy", 64'(o_busy), 64'd0);
    check_cnt("rst", 0, 0, 0, 0);

    i_rst_n = 1'b1;
    @(negedge clk);
    i_enable = 1'b1;

    // first frame after reset: one idle word; clear coincides with the TERM transfer
    send("a_idle", IDLE_W, 8'hFF);
    send("a_start", START_W, 8'h01);
    for (int i = 0; i < 3; i++) send("a_aa", AA_W, 8'h00);
    i_clr_cnt = 1'b1;
    send("a_term", TERM_W, 8'hFF);
    i_clr_cnt = 1'b0;
    check_cnt("a_clr", 0, 0, 0, 0);

    // reference fixed frame: idle 2, data 3
    fixed_frame("b", 2, 3);
    check_cnt("b", 31, 25, 1, 0);

    // incrementing with byte wrap; inputs changed mid-frame must not apply
    i_mode = 2'b01; i_pattern = 8'hFC; i_data_len = 16'd2;
    send("c_idle", IDLE_W, 8'hFF);
    send("c_idle", IDLE_W, 8'hFF);
    send("c_start", START_W, 8'h01);
    i_mode = 2'b00; i_pattern = 8'hAA; i_data_len = 16'd3;
    send("c_inc0", 64'h03020100FFFEFDFC, 8'h00);
    send("c_inc1", 64'h0B0A090807060504, 8'h00);
    send("c_term", TERM_W, 8'hFF);

    // LFSR mode from the seed, including a tap-feedback step
    i_mode = 2'b10; i_data_len = 16'd4;
    send("d_idle", IDLE_W, 8'hFF);
    send("d_idle", IDLE_W, 8'hFF);
    send("d_start", START_W, 8'h01);
    send("d_lfsr0", 64'hACE11234ACE11234, 8'h00);
    send("d_lfsr1", 64'h5670891A5670891A, 8'h00);
    send("d_lfsr2", 64'h2B38448D2B38448D, 8'h00);
    send("d_lfsr3", 64'h95BC224595BC2245, 8'h00);
    i_clr_cnt = 1'b1;
    send("d_term", TERM_W, 8'hFF);
    i_clr_cnt = 1'b0;

    // two injection pulses in idle corrupt only the first payload word
    i_mode = 2'b00; i_data_len = 16'd4;
    i_err_inject = 1'b1;
    send("e_idle", IDLE_W, 8'hFF);
    send("e_idle", IDLE_W, 8'hFF);
    i_err_inject = 1'b0;
    send("e_start", START_W, 8'h01);
    send("e_err", ERR_W, 8'h01);
    for (int i = 0; i < 3; i++) send("e_aa", AA_W, 8'h00);
    send("e_term", TERM_W, 8'hFF);
    check_cnt("e", 38, 26, 1, 1);

    // random back-pressure; totals must match the unstalled frames
    i_data_len = 16'd3;
    i_clr_cnt  = 1'b1;
    send("f_idle", IDLE_W, 8'hFF);
    i_clr_cnt  = 1'b0;
    stall_en   = 1'b1;
    fixed_frame("f0", 1, 3);
    fixed_frame("f1", 2, 3);
    fixed_frame("f2", 2, 3);
    stall_en   = 1'b0;
    check_cnt("f", 93, 67, 3, 0);

    // zero-length payload and zero idle length
    i_data_len = 16'd0; i_idle_len = 16'd0;
    send("g_idle", IDLE_W, 8'hFF);
    send("g_idle", IDLE_W, 8'hFF);
    send("g_start", START_W, 8'h01);
    send("g_term", TERM_W, 8'hFF);
    send("g_idle1", IDLE_W, 8'hFF);
    send("g_start", START_W, 8'h01);
    send("g_term", TERM_W, 8'hFF);

    // enable dropped during DATA: frame still terminates, then idles
    i_idle_len = 16'd1; i_data_len = 16'd3;
    send("h_idle", IDLE_W, 8'hFF);
    send("h_start", START_W, 8'h01);
    send("h_aa", AA_W, 8'h00);
    i_enable = 1'b0;
    send("h_aa", AA_W, 8'h00);
    send("h_aa", AA_W, 8'h00);
    send("h_term", TERM_W, 8'hFF);
    for (int i = 0; i < 4; i++) send("h_idle", IDLE_W, 8'hFF);

    // saturation of the 8-bit ctrl-char counter, then clear with a transfer
    i_clr_cnt = 1'b1;
    send("s_idle", IDLE_W, 8'hFF);
    i_clr_cnt = 1'b0;
    for (int i = 0; i < 31; i++) send("s_idle", IDLE_W, 8'hFF);
    check_cnt("s_248", 0, 248, 0, 0);
    send("s_idle", IDLE_W, 8'hFF);
    check("s_sat", 64'(o_ctrl_char_cnt), 64'd255);
    send("s_idle", IDLE_W, 8'hFF);
    send("s_idle", IDLE_W, 8'hFF);
    check("s_sat_hold", 64'(o_ctrl_char_cnt), 64'd255);
    i_clr_cnt = 1'b1;
    send("s_idle", IDLE_W, 8'hFF);
    i_clr_cnt = 1'b0;
    check_cnt("s_clr", 0, 0, 0, 0);

    // asynchronous reset in the middle of a payload
    i_enable = 1'b1;
    send("r_idle", IDLE_W, 8'hFF);
    send("r_start", START_W, 8'h01);
    send("r_aa", AA_W, 8'h00);
    #2 i_rst_n = 1'b0;
    #1;
    check("r_valid", 64'(o_tx_valid), 64'd0);
    check("r_data", o_tx_data, IDLE_W);
    check("r_ctrl", 64'(o_tx_ctrl), 64'hFF);
    check("r_busy", 64'(o_busy), 64'd0);
    check("r_ctrl_chars", 64'(o_ctrl_char_cnt), 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(negedge clk);
    send("r2_idle", IDLE_W, 8'hFF);
    send("r2_start", START_W, 8'h01);
    send("r2_aa", AA_W, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mii_frame_gen.md
Name: mii_frame_gen

Overview:
Parametrised multi-lane xMII frame generator. Successor to the fixed-length 1.6T MII generator.
- Adds per-lane control bits, runtime idle/payload lengths and three payload modes.
- Adds a valid/ready output handshake, error-code injection and saturating character/frame statistics.
- Sits between test/traffic logic and the PCS encoder; also serves as bench stimulus source.

Parameters:
- DATA_WIDTH, 64, data bus width; multiple of 8, >=32. NB = DATA_WIDTH/8 lanes; lane k = bits [8k+7:8k].
- LEN_WIDTH, 16, width of runtime length inputs.
- CNT_WIDTH, 32, width of statistics counters.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- EOF_CODE, 8'hFD, terminate control character.
- ERROR_CODE, 8'hFE, error control character.
- LFSR_SEED, 32'hACE11234, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  1 = start new frames; 0 = finish current frame then idle
- i_mode  in  2  00 fixed, 01 incrementing, 10 LFSR, 11 treated as 00
- i_pattern  in  8  fixed byte / incrementing base
- i_idle_len  in  LEN_WIDTH  idle words between frames; 0 treated as 1
- i_data_len  in  LEN_WIDTH  payload words per frame; 0 allowed
- i_err_inject  in  1  pulse; corrupt next transferred payload word
- i_clr_cnt  in  1  synchronous clear of all counters
- i_ready  in  1  downstream accepts word
- o_tx_valid  out  1  word valid
- o_tx_data  out  DATA_WIDTH  lane data
- o_tx_ctrl  out  NB  per-lane control flag (1 = control char)
- o_busy  out  1  FSM outside IDLE
- o_frame_cnt  out  CNT_WIDTH  frames completed
- o_data_char_cnt  out  CNT_WIDTH  transferred lanes with ctrl=0
- o_ctrl_char_cnt  out  CNT_WIDTH  transferred lanes with ctrl=1
- o_err_cnt  out  CNT_WIDTH  error words transferred

Behaviour:
Reset (async assert, sync release):
- o_tx_data = {NB{IDLE_CODE}}, o_tx_ctrl = all 1, o_tx_valid = 0, o_busy = 0.
- Counters = 0, LFSR = LFSR_SEED, err-pending = 0, state IDLE with idle counter loaded to 1.

Handshake:
- o_tx_valid rises the first cycle after reset release and stays 1.
- Transfer = valid & ready. All outputs are registered.
- Outputs and state hold while ready = 0.
- The next word appears the cycle after a transfer; a word is never dropped or duplicated.

FSM, advancing only on transfer:
- IDLE: word = all lanes IDLE_CODE, ctrl all 1. After the idle count is exhausted and i_enable = 1 -> START; if i_enable = 0, stay IDLE.
- START: one word. Lane0 = START_CODE (ctrl 1); lanes 1..NB-2 = 8'h55 (ctrl 0); lane NB-1 = 8'hD5 (ctrl 0). Latch i_data_len, i_mode, i_pattern at entry. Next: DATA if latched len > 0, else TERM.
- DATA: latched-length words, all ctrl 0. Next: TERM.
  - Fixed mode: every lane = pattern.
  - Incrementing mode: lane k = (base + k) mod 256. Base = pattern at frame start, +NB per word, wraps mod 256.
  - LFSR mode: lane k = LFSR byte (k mod 4). Galois LFSR, poly x^32+x^22+x^2+x+1, steps once per transferred DATA word; free-running across frames.
- TERM: lane0 = EOF_CODE, remaining lanes IDLE_CODE, all ctrl 1. Next: IDLE, loading the idle count from i_idle_len (0 -> 1).
- o_busy = 1 in START, DATA, TERM.
- i_enable deasserted mid-frame: frame completes through TERM.
- Length/mode input changes mid-frame: take effect next frame only.

Error injection:
- i_err_inject sets err-pending.
- The next DATA word presented has lane0 = ERROR_CODE with ctrl[0] = 1; other lanes unchanged.
- err-pending clears on that word's transfer.
- Further pulses while pending do not stack. Pending survives across idle/frames.

Counters, on each transfer:
- data_char += count of ctrl = 0 lanes; ctrl_char += count of ctrl = 1 lanes.
- frame_cnt +1 on TERM; err_cnt +1 on injected word.
- All counters saturate at all-ones.
- i_clr_cnt has priority: the counter result that cycle is 0, and that cycle's transfer is not counted.

Reset mid-frame: immediate return to reset state; no TERM emitted.

Test Plan:
- DATA_WIDTH=64, idle 2, data 3, fixed 8'hAA, ready = 1 -> per frame: 2 idle words, START (FB,55x6,D5; ctrl 8'h01), 3 words 8'hAA x8 (ctrl 0), TERM (FD + 07x7; ctrl 8'hFF). After 1 frame: data_char 31, ctrl_char 25, frame_cnt 1.
- Incrementing, pattern 8'hFC, data 2 -> word0 lanes FC,FD,FE,FF,00,01,02,03; word1 lanes 04..0B (wrap verified).
- Ready toggled 1,0,0,1 randomly (~40% low) across 20 frames -> every word held stable while ready = 0; counter totals equal the ready = 1 reference run.
- err_inject pulsed twice during idle, data 4 -> only first payload word has lane0 FE, ctrl 8'h01; err_cnt 1; data_char per frame 7+31 = 38.
- data_len 0, idle_len 0 -> START directly followed by TERM, 1 idle word between frames. Deassert i_enable during DATA -> TERM still emitted, then IDLE indefinitely with o_busy 0.
- Force counter to max-1 via long run (CNT_WIDTH=8) -> saturates at 255; i_clr_cnt concurrent with transfer -> counter 0. Async reset mid-DATA -> outputs idle, valid 0 immediately.
